// File: rtl/arrow_lane_sequencer.sv
// Arrow lane sequencer: scrolls one player's arrow slots, pulls chart steps over valid/ready
// and judges button presses against the hit window around EXCELLENT_SLOT.
module arrow_lane_sequencer #(
  parameter int unsigned NUM_SLOTS        = 26,
  parameter int unsigned STEP_FRAMES      = 4,
  parameter int unsigned EXCELLENT_SLOT   = 23,
  parameter int unsigned INDICATOR_FRAMES = 30,
  parameter int unsigned SCORE_W          = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic                   chart_valid,
  input  logic [2:0]             chart_arrow,
  input  logic                   chart_last,
  output logic                   chart_ready,
  input  logic [4:0]             buttons,
  output logic [3*NUM_SLOTS-1:0] arrow_array,
  output logic [1:0]             indicator,
  output logic [SCORE_W-1:0]     score,
  output logic                   busy,
  output logic                   done
);
  localparam int unsigned AW   = 3 * NUM_SLOTS;
  localparam int unsigned CntW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned TmrW = $clog2(INDICATOR_FRAMES + 1);
  localparam int unsigned ExLo = 3 * EXCELLENT_SLOT;
  localparam int unsigned EaLo = 3 * (EXCELLENT_SLOT - 1);
  localparam int unsigned LaLo = 3 * (EXCELLENT_SLOT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]      arr_q, arr_d;
  logic [1:0]         ind_q, ind_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [4:0]         btn_q, pend_q, pend_d;
  logic               done_q, done_d, shifted_q, shifted_d;

  logic               step, xfer, ind_wr;
  logic [4:0]         edges, judge_vec;
  logic [2:0]         code, slot0_in;
  logic [1:0]         ind_val, pts;
  logic [SCORE_W:0]   score_sum;

  function automatic logic [2:0] press_code(input logic [4:0] vec);
    case (vec)
      5'b00001: return 3'b110;
      5'b00010: return 3'b010;
      5'b00100: return 3'b001;
      5'b01000: return 3'b011;
      5'b10000: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  assign busy        = (state_q != StIdle);
  assign step        = busy && frame_tick && (cnt_q == CntW'(STEP_FRAMES - 1));
  assign chart_ready = (state_q == StRun) && step;
  assign xfer        = chart_valid && chart_ready;
  assign edges       = buttons & ~btn_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_d     = arr_q;
    ind_d     = ind_q;
    tmr_d     = tmr_q;
    score_d   = score_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    shifted_d = 1'b0;
    judge_vec = '0;
    code      = '0;
    slot0_in  = '0;
    ind_wr    = 1'b0;
    ind_val   = '0;
    pts       = '0;
    score_sum = '0;

    if (frame_tick && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
      if (tmr_q == TmrW'(1)) ind_d = 2'b00;
    end

    unique case (state_q)
      StIdle: begin
        arr_d  = '0;
        cnt_d  = '0;
        pend_d = '0;
        if (start) begin
          state_d = StRun;
          score_d = '0;
          ind_d   = '0;
          tmr_d   = '0;
        end
      end
      StRun, StDrain: begin
        if (frame_tick) cnt_d = step ? '0 : cnt_q + 1'b1;
        if (step) begin
          if (xfer && (chart_arrow != 3'b101) && (chart_arrow != 3'b111)) slot0_in = chart_arrow;
          arr_d     = {arr_q[AW-4:0], slot0_in};
          shifted_d = 1'b1;
          if (arr_q[AW-1 -: 3] != 3'b000) begin
            ind_wr  = 1'b1;
            ind_val = 2'b01;
          end
          // Edges on a step cycle wait one cycle so they see the shifted array.
          if (edges != '0) pend_d = edges;
          if (xfer && chart_last) state_d = StDrain;
        end else begin
          judge_vec = (edges != '0) ? edges : pend_q;
          pend_d    = '0;
          code      = press_code(judge_vec);
          if (judge_vec != '0) begin
            ind_wr = 1'b1;
            if ((judge_vec & (judge_vec - 5'd1)) != '0) begin
              ind_val = 2'b01;
            end else if (arr_q[ExLo +: 3] == code) begin
              arr_d[ExLo +: 3] = 3'b000;
              ind_val          = 2'b11;
              pts              = 2'd2;
            end else if (arr_q[EaLo +: 3] == code) begin
              arr_d[EaLo +: 3] = 3'b000;
              ind_val          = 2'b10;
              pts              = 2'd1;
            end else if (arr_q[LaLo +: 3] == code) begin
              arr_d[LaLo +: 3] = 3'b000;
              ind_val          = 2'b10;
              pts              = 2'd1;
            end else begin
              ind_val = 2'b01;
            end
          end
        end
        if ((state_q == StDrain) && shifted_q && (arr_q == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ind_wr) begin
      ind_d = ind_val;
      tmr_d = TmrW'(INDICATOR_FRAMES);
    end
    if (pts != '0) begin
      score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
      score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      arr_q     <= '0;
      ind_q     <= '0;
      tmr_q     <= '0;
      score_q   <= '0;
      btn_q     <= '0;
      pend_q    <= '0;
      done_q    <= 1'b0;
      shifted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arr_q     <= arr_d;
      ind_q     <= ind_d;
      tmr_q     <= tmr_d;
      score_q   <= score_d;
      btn_q     <= buttons;
      pend_q    <= pend_d;
      done_q    <= done_d;
      shifted_q <= shifted_d;
    end
  end

  assign arrow_array = arr_q;
  assign indicator   = ind_q;
  assign score       = score_q;
  assign done        = done_q;

endmodule

// File: tb/tb_arrow_lane_sequencer.sv
// Directed scenarios for arrow_lane_sequencer with a slot model; judgement results are queued
// when the stimulus is driven and compared the cycle they appear.
module tb_arrow_lane_sequencer;
  logic        clock = 1'b0;
  logic        resetn, start, frame_tick, chart_valid, chart_last, chart_ready;
  logic [2:0]  chart_arrow;
  logic [4:0]  buttons;
  logic [77:0] arrow_array;
  logic [1:0]  indicator;
  logic [15:0] score;
  logic        busy, done;

  always #5 clock = ~clock;

  arrow_lane_sequencer dut (
    .clock(clock), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .chart_valid(chart_valid), .chart_arrow(chart_arrow), .chart_last(chart_last),
    .chart_ready(chart_ready), .buttons(buttons), .arrow_array(arrow_array),
    .indicator(indicator), .score(score), .busy(busy), .done(done)
  );

  typedef struct {
    logic [77:0] arr;
    logic [1:0]  ind;
    logic [15:0] score;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [2:0] m_slot [26];
  int         fc;
  bit         m_run;
  bit         m_miss;

  function automatic logic [77:0] model_arr();
    logic [77:0] v;
    for (int k = 0; k < 26; k++) v[3*k +: 3] = m_slot[k];
    return v;
  endfunction

  function automatic bit model_empty();
    return model_arr() == '0;
  endfunction

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic sb_push(input logic [77:0] a, input logic [1:0] i, input logic [15:0] s);
    exp_t e;
    e.arr = a; e.ind = i; e.score = s;
    sb.push_back(e);
  endtask

  task automatic frame(input logic v, input logic [2:0] a, input logic l, input logic [4:0] b,
                       output logic rdy);
    frame_tick = 1'b1; chart_valid = v; chart_arrow = a; chart_last = l; buttons = b;
    #1 rdy = chart_ready;
    @(negedge clock);
    frame_tick = 1'b0; chart_valid = 1'b0; chart_last = 1'b0;
    fc++;
  endtask

  // Runs frames up to and including the next scroll step, updating the slot model.
  task automatic do_step(input logic v, input logic [2:0] a, input logic l, input logic [4:0] b,
                         output logic rdy);
    logic       r;
    logic [2:0] ins;
    while (((fc + 1) % 4) != 0) frame(1'b0, 3'b000, 1'b0, buttons, r);
    frame(v, a, l, b, rdy);
    ins    = (m_run && v && a != 3'b101 && a != 3'b111) ? a : 3'b000;
    m_miss = (m_slot[25] != 3'b000);
    for (int k = 25; k > 0; k--) m_slot[k] = m_slot[k-1];
    m_slot[0] = ins;
    if (m_run && v && l) m_run = 1'b0;
  endtask

  task automatic gaps(input int n);
    logic r;
    repeat (n) do_step(1'b0, 3'b000, 1'b0, 5'b0, r);
  endtask

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; frame_tick = 1'b0; chart_valid = 1'b0;
    chart_arrow = 3'b000; chart_last = 1'b0; buttons = 5'b0;
    cyc(); cyc();
    resetn = 1'b1;
    for (int k = 0; k < 26; k++) m_slot[k] = 3'b000;
    m_run = 1'b0; fc = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    fc = 0; m_run = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (arrow_array !== '0) $display("FAIL reset_arr: got %h want 0", arrow_array); else n_pass++;
    n_checks++; if (indicator !== 2'b00) $display("FAIL reset_ind: got %b want 00", indicator); else n_pass++;
    n_checks++; if (score !== 16'd0) $display("FAIL reset_score: got %0d want 0", score); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (chart_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", chart_ready); else n_pass++;
  endtask

  task automatic test_fill();
    logic        r;
    logic [77:0] all_up;
    for (int k = 0; k < 26; k++) all_up[3*k +: 3] = 3'b001;
    do_reset(); do_start();
    for (int i = 1; i <= 104; i++) begin
      frame(1'b1, 3'b001, 1'b0, 5'b0, r);
      n_checks++;
      if (r !== ((i % 4) == 0)) $display("FAIL fill_ready tick %0d: got %b want %b", i, r, (i % 4) == 0);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (arrow_array !== 78'd1) $display("FAIL fill_first: got %h want 1", arrow_array); else n_pass++;
      end
    end
    n_checks++; if (arrow_array !== all_up) $display("FAIL fill_full: got %h want %h", arrow_array, all_up); else n_pass++;
    n_checks++; if (indicator !== 2'b00) $display("FAIL fill_ind: got %b want 00", indicator); else n_pass++;
  endtask

  task automatic test_excellent();
    logic r;
    exp_t e;
    do_reset(); do_start();
    do_step(1'b1, 3'b011, 1'b0, 5'b0, r);
    gaps(23);
    n_checks++; if (arrow_array[69 +: 3] !== 3'b011) $display("FAIL exc_slot23: got %b want 011", arrow_array[69 +: 3]); else n_pass++;
    m_slot[23] = 3'b000;
    sb_push(model_arr(), 2'b11, 16'd2);
    buttons = 5'b01000;
    cyc();
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL exc_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL exc_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL exc_score: got %0d want %0d", score, e.score); else n_pass++;
    buttons = 5'b0;
    cyc();
    for (int i = 0; i < 29; i++) frame(1'b0, 3'b000, 1'b0, 5'b0, r);
    n_checks++; if (indicator !== 2'b11) $display("FAIL exc_hold29: got %b want 11", indicator); else n_pass++;
    frame(1'b0, 3'b000, 1'b0, 5'b0, r);
    n_checks++; if (indicator !== 2'b00) $display("FAIL exc_clear30: got %b want 00", indicator); else n_pass++;
  endtask

  task automatic test_good_bad();
    logic r;
    exp_t e;
    do_reset(); do_start();
    do_step(1'b1, 3'b100, 1'b0, 5'b0, r);
    do_step(1'b1, 3'b001, 1'b0, 5'b0, r);
    gaps(21);
    m_slot[22] = 3'b000;
    sb_push(model_arr(), 2'b10, 16'd1);
    buttons = 5'b10000;
    cyc();
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL good_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL good_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL good_score: got %0d want %0d", score, e.score); else n_pass++;
    buttons = 5'b0;
    cyc();
    sb_push(model_arr(), 2'b01, 16'd1);
    buttons = 5'b00100;
    cyc();
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL bad_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL bad_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL bad_score: got %0d want %0d", score, e.score); else n_pass++;
    buttons = 5'b0;
    cyc();
  endtask

  task automatic test_miss();
    logic r;
    exp_t e;
    do_reset(); do_start();
    do_step(1'b1, 3'b110, 1'b0, 5'b0, r);
    gaps(25);
    n_checks++; if (arrow_array[75 +: 3] !== 3'b110) $display("FAIL miss_slot25: got %b want 110", arrow_array[75 +: 3]); else n_pass++;
    n_checks++; if (indicator !== 2'b00) $display("FAIL miss_pre_ind: got %b want 00", indicator); else n_pass++;
    sb_push(78'd0, 2'b01, 16'd0);
    gaps(1);
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL miss_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL miss_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL miss_score: got %0d want %0d", score, e.score); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic r;
    exp_t e;
    do_reset(); do_start();
    do_step(1'b1, 3'b010, 1'b0, 5'b0, r);
    do_step(1'b1, 3'b010, 1'b0, 5'b0, r);
    gaps(21);
    do_step(1'b0, 3'b000, 1'b0, 5'b00010, r);
    n_checks++; if (arrow_array !== model_arr()) $display("FAIL pend_shift: got %h want %h", arrow_array, model_arr()); else n_pass++;
    n_checks++; if (indicator !== 2'b00) $display("FAIL pend_wait: got %b want 00", indicator); else n_pass++;
    m_slot[23] = 3'b000;
    sb_push(model_arr(), 2'b11, 16'd2);
    cyc();
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL pend_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL pend_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL pend_score: got %0d want %0d", score, e.score); else n_pass++;
    buttons = 5'b0;
    cyc();
    sb_push(model_arr(), 2'b01, 16'd2);
    buttons = 5'b00110;
    cyc();
    e = sb.pop_front();
    n_checks++; if (arrow_array !== e.arr) $display("FAIL multi_arr: got %h want %h", arrow_array, e.arr); else n_pass++;
    n_checks++; if (indicator !== e.ind) $display("FAIL multi_ind: got %b want %b", indicator, e.ind); else n_pass++;
    n_checks++; if (score !== e.score) $display("FAIL multi_score: got %0d want %0d", score, e.score); else n_pass++;
    buttons = 5'b0;
    cyc();
  endtask

  task automatic test_drain();
    logic r;
    do_reset(); do_start();
    do_step(1'b1, 3'b001, 1'b0, 5'b0, r);
    n_checks++; if (r !== 1'b1) $display("FAIL drain_xfer1: got %b want 1", r); else n_pass++;
    do_step(1'b1, 3'b011, 1'b0, 5'b0, r);
    n_checks++; if (r !== 1'b1) $display("FAIL drain_xfer2: got %b want 1", r); else n_pass++;
    do_step(1'b1, 3'b100, 1'b1, 5'b0, r);
    n_checks++; if (r !== 1'b1) $display("FAIL drain_xfer3: got %b want 1", r); else n_pass++;
    for (int s = 0; s < 40 && !model_empty(); s++) begin
      do_step(1'b1, 3'b001, 1'b0, 5'b0, r);
      n_checks++; if (r !== 1'b0) $display("FAIL drain_ready step %0d: got %b want 0", s, r); else n_pass++;
    end
    n_checks++; if (arrow_array !== '0) $display("FAIL drain_empty: got %h want 0", arrow_array); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL drain_early_done: got %b want 0", done); else n_pass++;
    n_checks++; if (indicator !== 2'b01) $display("FAIL drain_miss_ind: got %b want 01", indicator); else n_pass++;
    cyc();
    n_checks++; if (done !== 1'b1) $display("FAIL drain_done: got %b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL drain_idle: got %b want 0", busy); else n_pass++;
    cyc();
    n_checks++; if (done !== 1'b0) $display("FAIL drain_done_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic r;
    do_reset(); do_start();
    do_step(1'b1, 3'b001, 1'b0, 5'b0, r);
    do_step(1'b1, 3'b100, 1'b0, 5'b0, r);
    buttons = 5'b00001;
    cyc();
    buttons = 5'b0;
    n_checks++; if (indicator !== 2'b01) $display("FAIL mid_pre_ind: got %b want 01", indicator); else n_pass++;
    n_checks++; if (arrow_array !== model_arr()) $display("FAIL mid_pre_arr: got %h want %h", arrow_array, model_arr()); else n_pass++;
    resetn = 1'b0;
    cyc();
    frame_tick = 1'b1;
    #1;
    n_checks++; if (arrow_array !== '0) $display("FAIL mid_arr: got %h want 0", arrow_array); else n_pass++;
    n_checks++; if (indicator !== 2'b00) $display("FAIL mid_ind: got %b want 00", indicator); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (chart_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", chart_ready); else n_pass++;
    frame_tick = 1'b0;
    resetn = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_excellent();
    test_good_bad();
    test_miss();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
